// File: rtl/herm_rmv_pkg.sv
// Shared types and sizing helpers for the Hermitian-remover frame sequencer.
package herm_rmv_pkg;

  // Controller states; CLEAR re-arms the remover through tx_done.
  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StLoad,
    StWaitFull,
    StDrain
  } state_e;

  // Words written per burst.
  function automatic int unsigned n_in(input int unsigned fft_point, input int unsigned sym_num);
    return fft_point * sym_num;
  endfunction

  // Active-subcarrier words read back per burst.
  function automatic int unsigned n_out(input int unsigned active_sc, input int unsigned sym_num);
    return active_sc * sym_num;
  endfunction

  // Bits needed to hold 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Widths for the default 64-point, 12-symbol, 28-subcarrier configuration.
  localparam int unsigned InCntW = cnt_w(n_in(64, 12));   // 10
  localparam int unsigned RdCntW = cnt_w(n_out(28, 12));  // 9
  localparam int unsigned TimerW = cnt_w(2048 - 1);       // 11

endpackage

// File: rtl/herm_rmv_skid_fifo.sv
// Small synchronous FIFO absorbing remover read returns while downstream stalls.
module herm_rmv_skid_fifo
  import herm_rmv_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 17
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic [Width-1:0]          wdata_i,
  input  logic                      pop_i,
  output logic [Width-1:0]          rdata_o,
  output logic                      valid_o,
  output logic [cnt_w(Depth)-1:0]   count_o
);

  localparam int unsigned CntW = cnt_w(Depth);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Guarded handshakes and pointer/count next state.
  always_comb begin
    do_push  = push_i && (count_q != CntFull);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only visible while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/herm_rmv_ctrl.sv
// Frame sequencer: loads one FFT burst into the remover, waits for it to fill,
// then drains the active subcarriers downstream and re-arms the remover.
module herm_rmv_ctrl
  import herm_rmv_pkg::*;
#(
  parameter int unsigned FFT_POINT = 64,
  parameter int unsigned SYM_NUM   = 12,
  parameter int unsigned ACTIVE_SC = 28,
  parameter int unsigned DW        = 16,
  parameter int unsigned READ_LAT  = 3,
  parameter int unsigned TIMEOUT   = 2048
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic [DW-1:0] rmv_din,
  output logic          rmv_wren,
  output logic          rmv_tx_done,
  output logic [8:0]    rmv_read_ptr,
  input  logic          rmv_out_buff_full,
  input  logic [DW-1:0] rmv_dout,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          err_timeout
);

  localparam int unsigned NIn       = n_in(FFT_POINT, SYM_NUM);
  localparam int unsigned NOut      = n_out(ACTIVE_SC, SYM_NUM);
  localparam int unsigned InW       = cnt_w(NIn);
  localparam int unsigned RdW       = cnt_w(NOut);
  localparam int unsigned TmrW      = cnt_w(TIMEOUT - 1);
  localparam int unsigned FifoDepth = READ_LAT + 1;
  localparam int unsigned FifoCntW  = cnt_w(FifoDepth);

  localparam logic [InW-1:0]    InLast  = InW'(NIn - 1);
  localparam logic [InW-1:0]    InMax   = InW'(NIn);
  localparam logic [RdW-1:0]    RdLast  = RdW'(NOut - 1);
  localparam logic [RdW-1:0]    RdMax   = RdW'(NOut);
  localparam logic [TmrW-1:0]   TmrLast = TmrW'(TIMEOUT - 1);
  localparam logic [FifoCntW:0] SlotMax = (FifoCntW + 1)'(FifoDepth);

  state_e              state_q, state_d;
  logic [InW-1:0]      in_cnt_q, in_cnt_d;
  logic [RdW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic                err_q, err_d;
  logic                frame_done_q, frame_done_d;
  logic [8:0]          ptr_q, ptr_d;
  logic [READ_LAT-1:0] vld_q, vld_d;  // reads in flight through the remover
  logic [READ_LAT-1:0] lst_q, lst_d;  // matching last-word tags

  logic                s_hs, issue, push, pop;
  logic [DW:0]         fifo_rdata;
  logic                fifo_valid;
  logic [FifoCntW-1:0] fifo_count;
  logic [FifoCntW:0]   used_slots;

  // Stream-side handshakes, read credit and remover-facing outputs.
  always_comb begin
    s_ready = !rst && ((state_q == StIdle) || ((state_q == StLoad) && (in_cnt_q < InMax)));
    s_hs    = s_valid && s_ready;
    pop     = fifo_valid && m_ready;
    push    = vld_q[READ_LAT-1];
    // A word popped this cycle frees its slot, so it is not counted against the credit;
    // this keeps one read per cycle in flight while m_ready stays high.
    used_slots = {1'b0, fifo_count} + (FifoCntW + 1)'($countones(vld_q))
                 - (FifoCntW + 1)'(pop);
    issue = (state_q == StDrain) && (rd_cnt_q < RdMax) && (used_slots < SlotMax);
    rmv_read_ptr = issue ? 9'(rd_cnt_q) : ptr_q;
    rmv_wren     = s_hs;
    rmv_din      = s_data;
    // The remover has no reset of its own, so reset also holds it cleared.
    rmv_tx_done  = rst || (state_q == StClear);
    busy         = !rst && (state_q != StIdle);
  end

  // Next-state logic for the sequencer and its counters.
  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    timer_d      = timer_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    ptr_d        = issue ? 9'(rd_cnt_q) : ptr_q;
    vld_d        = vld_q << 1;
    vld_d[0]     = issue;
    lst_d        = lst_q << 1;
    lst_d[0]     = issue && (rd_cnt_q == RdLast);

    unique case (state_q)
      StClear: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (s_hs) begin
          err_d    = 1'b0;
          in_cnt_d = InW'(1);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (s_hs) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == InLast) begin
            timer_d = '0;
            state_d = StWaitFull;
          end
        end
      end
      StWaitFull: begin
        if (rmv_out_buff_full) begin
          rd_cnt_d = '0;
          state_d  = StDrain;
        end else if (timer_q == TmrLast) begin
          err_d   = 1'b1;
          state_d = StClear;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDrain: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (pop && fifo_rdata[DW]) begin
          frame_done_d = 1'b1;
          state_d      = StClear;
        end
      end
      default: begin
        state_d = StClear;
      end
    endcase

    if (state_q != StDrain) begin
      vld_d = '0;
      lst_d = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClear;
      in_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      ptr_q        <= '0;
      vld_q        <= '0;
      lst_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      ptr_q        <= ptr_d;
      vld_q        <= vld_d;
      lst_q        <= lst_d;
    end
  end

  herm_rmv_skid_fifo #(
    .Depth (FifoDepth),
    .Width (DW + 1)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i ({lst_q[READ_LAT-1], rmv_dout}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign m_valid     = fifo_valid;
  assign m_data      = fifo_rdata[DW-1:0];
  assign m_last      = fifo_valid && fifo_rdata[DW];
  assign frame_done  = frame_done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_herm_rmv_ctrl.sv
// Self-checking bench for herm_rmv_ctrl with a behavioural remover model.
module tb_herm_rmv_ctrl;

  localparam int NIN      = 768;
  localparam int NOUT     = 336;
  localparam int READ_LAT = 3;
  localparam int TIMEOUT  = 2048;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [15:0] rmv_din, rmv_dout;
  logic        rmv_wren, rmv_tx_done, rmv_out_buff_full;
  logic [8:0]  rmv_read_ptr;
  logic        m_valid, m_last, m_ready;
  logic [15:0] m_data;
  logic        busy, frame_done, err_timeout;

  herm_rmv_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .s_valid           (s_valid),
    .s_data            (s_data),
    .s_ready           (s_ready),
    .rmv_din           (rmv_din),
    .rmv_wren          (rmv_wren),
    .rmv_tx_done       (rmv_tx_done),
    .rmv_read_ptr      (rmv_read_ptr),
    .rmv_out_buff_full (rmv_out_buff_full),
    .rmv_dout          (rmv_dout),
    .m_valid           (m_valid),
    .m_data            (m_data),
    .m_last            (m_last),
    .m_ready           (m_ready),
    .busy              (busy),
    .frame_done        (frame_done),
    .err_timeout       (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Remover model: keeps bins 1..14 and 50..63 of each symbol.
  function automatic int map_idx(input logic [8:0] k);
    int s, j, idx;
    s   = int'(k) / 28;
    j   = int'(k) % 28;
    idx = s * 64 + ((j < 14) ? j + 1 : j + 36);
    return (idx < NIN) ? idx : 0;
  endfunction

  logic [15:0] mem [NIN];
  int          wr_addr = 0;
  int          full_cnt = 0;
  bit          armed = 0;
  logic        full_r = 1'b0;
  logic [8:0]  p1 = '0, p2 = '0, p3 = '0;
  bit          full_en = 0;
  int          full_delay = 0;

  always @(posedge clk) begin
    p1 <= rmv_read_ptr;
    p2 <= p1;
    p3 <= p2;
    if (rmv_tx_done) begin
      wr_addr <= 0;
      full_r  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (rmv_wren && wr_addr < NIN) begin
        mem[wr_addr] <= rmv_din;
        wr_addr      <= wr_addr + 1;
        if (wr_addr == NIN - 1 && full_en) begin
          armed    <= 1'b1;
          full_cnt <= full_delay;
        end
      end
      if (armed) begin
        if (full_cnt == 0) begin
          full_r <= 1'b1;
          armed  <= 1'b0;
        end else begin
          full_cnt <= full_cnt - 1;
        end
      end
    end
  end

  assign rmv_dout          = mem[map_idx(p3)];
  assign rmv_out_buff_full = full_r;

  typedef struct {
    int          full_delay;
    bit          full_en;
    bit          gaps;
    bit          bp;
    logic [15:0] base;
    int          exp_words;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  vec_t vecs[6];
  exp_t exp_q[$];

  int n_err = 0, n_checks = 0;
  int wren_cnt, out_cnt, fifo_max, lat, full_cyc, first_hs_cyc, last_hs_cyc;
  bit frame_end, last_pending, full_prev, lat_arm, bp_mode;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output-side monitor: scoreboard pop, frame_done timing, occupancy, latency.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (last_pending) begin
        check("frame_done after last", int'(frame_done), 1);
        check("tx_done after last", int'(rmv_tx_done), 1);
        last_pending = 0;
      end else if (frame_done) begin
        check("spurious frame_done", int'(frame_done), 0);
      end
      if (rmv_wren) wren_cnt++;
      if (int'(dut.u_fifo.count_o) > fifo_max) fifo_max = int'(dut.u_fifo.count_o);
      if (rmv_out_buff_full && !full_prev) begin
        full_cyc = cyc;
        lat_arm  = 1;
      end
      full_prev = rmv_out_buff_full;
      if (m_valid && lat_arm) begin
        lat     = cyc - full_cyc;
        lat_arm = 0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected output: got data %0h, expected no word", m_data);
        end else begin
          e = exp_q.pop_front();
          check("out data", int'(m_data), int'(e.data));
          check("out last", int'(m_last), int'(e.last));
        end
        out_cnt++;
        if (out_cnt == 1) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        if (m_last) begin
          frame_end    = 1;
          last_pending = 1;
        end
      end
    end
  endtask

  // Downstream ready: always high, or 1-on/2-off when backpressure is selected.
  task automatic mready_drv();
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        m_ready = (ph == 0);
        ph      = (ph == 2) ? 0 : ph + 1;
      end else begin
        m_ready = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] base, input bit gaps);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < NIN && guard < 8 * NIN) begin
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = base + 16'(i);
      @(negedge clk);
      hs = s_valid && s_ready;
      step();
      guard++;
      if (hs) begin
        if (i == 0) check("err cleared on first handshake", int'(err_timeout), 0);
        i++;
      end
    end
    s_valid = 1'b0;
    check("input handshakes", i, NIN);
    check("s_ready drop after last input", int'(s_ready), 0);
    check("wren pulses", wren_cnt, NIN);
  endtask

  task automatic load_expected(input logic [15:0] base, input int words);
    exp_t e;
    for (int k = 0; k < words; k++) begin
      e.data = base + 16'(map_idx(9'(k)));
      e.last = (k == NOUT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_frame_stats();
    wren_cnt     = 0;
    out_cnt      = 0;
    frame_end    = 0;
    lat          = -1;
    lat_arm      = 0;
    fifo_max     = 0;
    first_hs_cyc = -1;
    last_hs_cyc  = -1;
  endtask

  task automatic run_vec(input vec_t v);
    int guard;
    clear_frame_stats();
    full_en    = v.full_en;
    full_delay = v.full_delay;
    bp_mode    = v.bp;
    load_expected(v.base, v.exp_words);
    send_frame(v.base, v.gaps);
    guard = 0;
    if (v.exp_err) begin
      while (!err_timeout && guard < TIMEOUT + 100) begin
        step();
        guard++;
      end
      check("timeout cycles", guard, TIMEOUT);
      check("timeout tx_done", int'(rmv_tx_done), 1);
      step();
      check("idle s_ready after timeout", int'(s_ready), 1);
      check("idle busy after timeout", int'(busy), 0);
      check("err_timeout sticky", int'(err_timeout), 1);
      check("no output on timeout", out_cnt, 0);
    end else begin
      while (!frame_end && guard < 6000) begin
        step();
        guard++;
      end
      check("frame end seen", int'(frame_end), 1);
      step();
      step();
      check("output words", out_cnt, v.exp_words);
      check("scoreboard drained", exp_q.size(), 0);
      check("first m_valid latency", lat, READ_LAT + 2);
      if (!v.bp) check("full throughput", last_hs_cyc - first_hs_cyc, NOUT - 1);
      check("fifo bound", int'(fifo_max <= READ_LAT + 1), 1);
      check("read_ptr holds last", int'(rmv_read_ptr), NOUT - 1);
      check("idle s_ready", int'(s_ready), 1);
      check("idle busy", int'(busy), 0);
      check("err_timeout clear", int'(err_timeout), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    int guard;
    vecs[0] = '{full_delay: 700, full_en: 1, gaps: 0, bp: 0, base: 16'h0000,
                exp_words: NOUT, exp_err: 0};
    vecs[1] = '{full_delay: 60, full_en: 1, gaps: 0, bp: 1, base: 16'h1000,
                exp_words: NOUT, exp_err: 0};
    vecs[2] = '{full_delay: 20, full_en: 1, gaps: 1, bp: 0, base: 16'h2000,
                exp_words: NOUT, exp_err: 0};
    vecs[3] = '{full_delay: 0, full_en: 0, gaps: 0, bp: 0, base: 16'h3000,
                exp_words: 0, exp_err: 1};
    vecs[4] = '{full_delay: 5, full_en: 1, gaps: 0, bp: 0, base: 16'h5000,
                exp_words: NOUT, exp_err: 0};
    vecs[5] = '{full_delay: 10, full_en: 1, gaps: 1, bp: 1, base: 16'h6000,
                exp_words: NOUT, exp_err: 0};

    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    bp_mode   = 0;
    full_prev = 0;
    last_pending = 0;
    clear_frame_stats();
    fork
      monitor();
      mready_drv();
    join_none

    // Reset: remover held cleared, stream closed.
    repeat (3) begin
      @(negedge clk);
      check("rst tx_done", int'(rmv_tx_done), 1);
      check("rst s_ready", int'(s_ready), 0);
      check("rst busy", int'(busy), 0);
      check("rst m_valid", int'(m_valid), 0);
      check("rst wren", int'(rmv_wren), 0);
      check("rst read_ptr", int'(rmv_read_ptr), 0);
      check("rst frame_done", int'(frame_done), 0);
      check("rst err_timeout", int'(err_timeout), 0);
    end
    step();
    rst = 1'b0;
    check("clear pulse tx_done", int'(rmv_tx_done), 1);
    check("clear pulse s_ready", int'(s_ready), 0);
    step();
    check("post-clear tx_done", int'(rmv_tx_done), 0);
    check("post-clear s_ready", int'(s_ready), 1);
    check("post-clear busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset in the middle of DRAIN, then a clean frame.
    clear_frame_stats();
    full_en    = 1;
    full_delay = 10;
    bp_mode    = 0;
    load_expected(16'h4000, NOUT);
    send_frame(16'h4000, 0);
    guard = 0;
    while (out_cnt < 100 && guard < 2000) begin
      step();
      guard++;
    end
    check("reached word 100", int'(out_cnt >= 100), 1);
    rst = 1'b1;
    step();
    check("m_valid after mid-drain rst", int'(m_valid), 0);
    check("tx_done during rst", int'(rmv_tx_done), 1);
    rst = 1'b0;
    exp_q.delete();
    check("tx_done pulse after rst", int'(rmv_tx_done), 1);
    step();
    check("idle after rst s_ready", int'(s_ready), 1);
    check("idle after rst tx_done", int'(rmv_tx_done), 0);
    run_vec(vecs[5]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
